ifu_fetch_queue: RTL and testbench

IFU_FETCH_QUEUE -- requirements
Module: ifu_fetch_queue

---
 rtl/ifu_fetch_queue.sv | 123 ++++++++++++
 tb/tb_ifu_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - instruction fetch request issue with an in-order, redirectable fetch queue
// Requests are credit-limited so that every in-flight response already owns a queue slot.
module ifu_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [XLEN-1:0]          mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [31:0]              mem_resp_data,
  input  logic                     mem_resp_err,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [XLEN-1:0]          inst_pc,
  output logic                     inst_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   drop;
  logic            halt;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;

  logic [31:0]     q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic            q_err  [DEPTH];

  logic [CW+1:0]   credits_used;
  logic            accept;
  logic            resp;
  logic            stale_resp;
  logic            live_resp;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_base;
  logic            unused_pc_bits;

  // Slots are reserved by queued, live in-flight and stale in-flight entries alike.
  assign credits_used  = (CW+2)'(occ) + (CW+2)'(outst) + (CW+2)'(drop);
  assign mem_req_valid = !rst && !halt && !redirect_valid && (credits_used < (CW+2)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign accept        = mem_req_valid && mem_req_ready;

  assign resp       = !rst && mem_resp_valid;
  assign stale_resp = resp && (drop != '0);
  assign live_resp  = resp && (drop == '0);
  assign push       = live_resp && !redirect_valid;

  assign inst_valid = !rst && (occ != '0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = q_data[rptr];
  assign inst_pc    = q_pc[rptr];
  assign inst_err   = q_err[rptr];
  assign count      = occ;

  assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      occ      <= '0;
      outst    <= '0;
      drop     <= '0;
      halt     <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight becomes stale; a same-cycle response retires one of them.
      fetch_pc <= redirect_base;
      resp_pc  <= redirect_base;
      occ      <= '0;
      outst    <= '0;
      drop     <= drop + outst - CW'(resp);
      halt     <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      outst <= outst + CW'(accept) - CW'(live_resp);
      if (stale_resp) begin
        drop <= drop - CW'(1);
      end
      if (live_resp) begin
        wptr    <= wptr + AW'(1);
        resp_pc <= resp_pc + XLEN'(4);
        if (mem_resp_err) begin
          halt <= 1'b1;
        end
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wptr] <= mem_resp_data;
      q_pc[wptr]   <= resp_pc;
      q_err[wptr]  <= mem_resp_err;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb/tb_ifu_fetch_queue.sv - randomized scoreboard bench for ifu_fetch_queue
// The model tracks the expected instruction stream by fetch epoch, not by the queue's internals.
module tb_ifu_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic [2:0]  count;

  ifu_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_err(inst_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } entry_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          epoch;
    int          cyc;
  } pend_t;

  entry_t      exp_q[$];
  pend_t       pend_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pops   = 0;
  int          epoch    = 0;
  int          cyc      = 0;
  int          model_occ = 0;
  logic [31:0] exp_fetch = RESET_PC;
  bit          halted   = 0;
  bit          err_en   = 0;
  bit          started  = 0;
  bit          prev_rst = 0;
  bit          prev_hold_inst = 0;
  bit          prev_hold_req  = 0;
  logic [31:0] prev_pc, prev_data, prev_addr;
  logic        prev_err;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return err_en && (((a >> 2) % 29) == 7);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic cycle(input int p_rdy, input int p_resp, input int p_irdy, input int p_redir,
                       input bit do_rst, input bit f_redir, input logic [31:0] f_pc);
    pend_t item;
    bit    have_resp, redir, exp_valid, accept, live, pop_m;
    @(negedge clk);
    if (started) chk("count", 64'(count), 64'(model_occ));
    started = 1;
    cyc++;
    rst = do_rst;
    have_resp = 0;
    if (!do_rst && pend_q.size() > 0 && pend_q[0].cyc < cyc && $urandom_range(99) < p_resp) begin
      have_resp = 1;
      item = pend_q.pop_front();
    end
    mem_resp_valid = have_resp;
    mem_resp_data  = have_resp ? item.data : $urandom;
    mem_resp_err   = have_resp ? item.err : 1'b0;
    redir = !do_rst && (f_redir || ($urandom_range(99) < (halted ? 25 : p_redir)));
    redirect_valid = redir;
    redirect_pc    = f_redir ? f_pc : {16'h8000, 16'($urandom)};
    mem_req_ready  = $urandom_range(99) < p_rdy;
    inst_ready     = $urandom_range(99) < p_irdy;
    #1;
    exp_valid = !do_rst && !redir && (model_occ != 0);
    chk("inst_valid", 64'(inst_valid), 64'(exp_valid));
    if (do_rst || redir) chk("req_valid_blocked", 64'(mem_req_valid), 64'(0));
    if (prev_rst && !do_rst) begin
      chk("first_req_valid", 64'(mem_req_valid), 64'(1));
      chk("first_req_addr", 64'(mem_req_addr), 64'(RESET_PC));
    end
    if (prev_hold_inst && !do_rst && !redir) begin
      chk("hold_inst_pc", 64'(inst_pc), 64'(prev_pc));
      chk("hold_inst_data", 64'(inst_data), 64'(prev_data));
      chk("hold_inst_err", 64'(inst_err), 64'(prev_err));
    end
    if (prev_hold_req && !do_rst && !redir && mem_req_valid)
      chk("hold_req_addr", 64'(mem_req_addr), 64'(prev_addr));
    accept = mem_req_valid && mem_req_ready;
    if (accept) begin
      chk("halt_blocks_req", 64'(halted), 64'(0));
      chk("req_addr", 64'(mem_req_addr), 64'(exp_fetch));
      exp_q.push_back('{pc: exp_fetch, data: data_of(exp_fetch), err: err_of(exp_fetch)});
      pend_q.push_back('{addr: exp_fetch, data: data_of(exp_fetch), err: err_of(exp_fetch),
                         epoch: epoch, cyc: cyc});
      exp_fetch += 32'd4;
    end
    live  = have_resp && (item.epoch == epoch) && !redir;
    pop_m = exp_valid && inst_ready;
    if (live && item.err) halted = 1;
    if (do_rst) begin
      model_occ = 0;
      exp_q.delete();
      pend_q.delete();
      exp_fetch = RESET_PC;
      halted = 0;
      epoch++;
    end else if (redir) begin
      model_occ = 0;
      exp_q.delete();
      exp_fetch = redirect_pc & ~32'h3;
      halted = 0;
      epoch++;
    end else begin
      model_occ = model_occ + int'(live) - int'(pop_m);
    end
    prev_rst       = do_rst;
    prev_hold_inst = inst_valid && !inst_ready;
    prev_hold_req  = mem_req_valid && !mem_req_ready;
    prev_pc   = inst_pc;
    prev_data = inst_data;
    prev_err  = inst_err;
    prev_addr = mem_req_addr;
  endtask

  // Monitor: every instruction the decoder takes must be the next expected one.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL pop_unexpected: got pc %0h expected no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", 64'(inst_pc), 64'(e.pc));
          chk("inst_data", 64'(inst_data), 64'(e.data));
          chk("inst_err", 64'(inst_err), 64'(e.err));
          n_pops++;
        end
      end
    end
  end

  task automatic stream(input int n, input bit check_bubbles);
    for (int i = 0; i < n; i++) begin
      cycle(100, 100, 100, 0, 0, 0, 32'h0);
      if (check_bubbles && i > 5) chk("no_bubble", 64'(inst_valid), 64'(1));
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    mem_resp_err = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;

    repeat (3) cycle(100, 100, 100, 0, 1, 0, 32'h0);
    stream(200, 1);

    // Build up two in-flight requests, then redirect to an unaligned target.
    repeat (2) cycle(100, 0, 100, 0, 0, 0, 32'h0);
    cycle(100, 0, 100, 0, 0, 1, 32'h8000_1002);
    stream(30, 0);

    // Decoder stall: the queue fills and the credit limit stops fetch.
    repeat (40) cycle(100, 100, 0, 0, 0, 0, 32'h0);
    chk("stall_count", 64'(count), 64'(DEPTH));
    chk("stall_req_valid", 64'(mem_req_valid), 64'(0));
    stream(50, 0);

    err_en = 1;
    repeat (3000) cycle(70, 60, 70, 2, 0, 0, 32'h0);

    // Reset mid-stream with a full queue.
    err_en = 0;
    cycle(100, 0, 100, 0, 0, 1, 32'h8000_2000);
    repeat (30) cycle(100, 100, 0, 0, 0, 0, 32'h0);
    repeat (3) cycle(100, 100, 100, 0, 1, 0, 32'h0);
    chk("reset_count", 64'(count), 64'(0));
    stream(100, 1);

    err_en = 1;
    repeat (1500) cycle(80, 50, 60, 3, 0, 0, 32'h0);

    @(negedge clk);
    chk("progress", 64'(n_pops > 500), 64'(1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
